// File: rtl/mem_port_arbiter_if.sv
// Signal bundle for mem_port_arbiter: two core-side req/gnt/rvalid ports and the shared sp_ram port.
// Suffixes are from the arbiter's point of view; the arbiter uses modport slave, the environment master.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              m0_req_i;
    logic              m0_we_i;
    logic [ADDR_W-1:0] m0_addr_i;
    logic [DATA_W/8-1:0] m0_be_i;
    logic [DATA_W-1:0] m0_wdata_i;
    logic              m0_gnt_o;
    logic              m0_rvalid_o;
    logic [DATA_W-1:0] m0_rdata_o;

    logic              m1_req_i;
    logic              m1_we_i;
    logic [ADDR_W-1:0] m1_addr_i;
    logic [DATA_W/8-1:0] m1_be_i;
    logic [DATA_W-1:0] m1_wdata_i;
    logic              m1_gnt_o;
    logic              m1_rvalid_o;
    logic [DATA_W-1:0] m1_rdata_o;

    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W/8-1:0] mem_be_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              mem_gnt_i;
    logic              mem_rvalid_i;
    logic [DATA_W-1:0] mem_rdata_i;

    logic              protocol_err_o;

    modport slave (
        input  m0_req_i, m0_we_i, m0_addr_i, m0_be_i, m0_wdata_i,
        output m0_gnt_o, m0_rvalid_o, m0_rdata_o,
        input  m1_req_i, m1_we_i, m1_addr_i, m1_be_i, m1_wdata_i,
        output m1_gnt_o, m1_rvalid_o, m1_rdata_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output protocol_err_o
    );

    modport master (
        output m0_req_i, m0_we_i, m0_addr_i, m0_be_i, m0_wdata_i,
        input  m0_gnt_o, m0_rvalid_o, m0_rdata_o,
        output m1_req_i, m1_we_i, m1_addr_i, m1_be_i, m1_wdata_i,
        input  m1_gnt_o, m1_rvalid_o, m1_rdata_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  protocol_err_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one sp_ram port between the core instruction (m0) and data (m1) ports.
// Responses are routed back through an in-order owner FIFO; a stalled selection is held until granted.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MAX_OUT = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    mem_port_arbiter_if.slave bus
);
    // Handshake: a request (req plus payload) is held until gnt is seen in the same cycle, which
    // accepts it; each accepted request later receives exactly one rvalid pulse, in accept order.

    localparam int              CNT_W   = $clog2(MAX_OUT + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

    logic               last_q, last_d;
    logic               lock_q, lock_d;
    logic               lock_id_q, lock_id_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [MAX_OUT-1:0] fifo_q, fifo_d;
    logic [CNT_W-1:0]   wr_idx;

    logic               sel;
    logic               sel_req;
    logic               full;
    logic               mem_req;
    logic               accept;
    logic               pop;
    logic               we_mux;
    logic [ADDR_W-1:0]  addr_mux;
    logic [DATA_W/8-1:0] be_mux;
    logic [DATA_W-1:0]  wdata_mux;

    always_comb begin
        sel = 1'b0;
        if (lock_q) begin
            sel = lock_id_q;
        end else if (bus.m0_req_i && !bus.m1_req_i) begin
            sel = 1'b0;
        end else if (!bus.m0_req_i && bus.m1_req_i) begin
            sel = 1'b1;
        end else if (bus.m0_req_i && bus.m1_req_i) begin
            sel = ~last_q;
        end
    end

    // Full is judged on the registered count so a same-cycle pop never opens an extra slot.
    assign sel_req = sel ? bus.m1_req_i : bus.m0_req_i;
    assign full    = (cnt_q == MAX_CNT);
    assign mem_req = sel_req & ~full;
    assign accept  = mem_req & bus.mem_gnt_i;
    assign pop     = bus.mem_rvalid_i & (cnt_q != '0);

    always_comb begin
        we_mux    = 1'b0;
        addr_mux  = '0;
        be_mux    = '0;
        wdata_mux = '0;
        if (mem_req) begin
            we_mux    = sel ? bus.m1_we_i    : bus.m0_we_i;
            addr_mux  = sel ? bus.m1_addr_i  : bus.m0_addr_i;
            be_mux    = sel ? bus.m1_be_i    : bus.m0_be_i;
            wdata_mux = sel ? bus.m1_wdata_i : bus.m0_wdata_i;
        end
    end

    assign bus.mem_req_o   = mem_req;
    assign bus.mem_we_o    = we_mux;
    assign bus.mem_addr_o  = addr_mux;
    assign bus.mem_be_o    = be_mux;
    assign bus.mem_wdata_o = wdata_mux;

    assign bus.m0_gnt_o    = accept & ~sel;
    assign bus.m1_gnt_o    = accept & sel;
    assign bus.m0_rvalid_o = pop & ~fifo_q[0];
    assign bus.m1_rvalid_o = pop & fifo_q[0];
    assign bus.m0_rdata_o  = bus.mem_rdata_i;
    assign bus.m1_rdata_o  = bus.mem_rdata_i;
    assign bus.protocol_err_o = err_q;

    always_comb begin
        last_d    = last_q;
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        if (accept) begin
            last_d = sel;
            lock_d = 1'b0;
        end else if (mem_req) begin
            lock_d    = 1'b1;
            lock_id_d = sel;
        end else if (lock_q && !(lock_id_q ? bus.m1_req_i : bus.m0_req_i)) begin
            lock_d = 1'b0;
        end
    end

    // Owner FIFO is a shift register: head at index 0, new entry lands behind the survivors.
    always_comb begin
        err_d  = err_q | (bus.mem_rvalid_i & (cnt_q == '0));
        cnt_d  = cnt_q + CNT_W'(accept) - CNT_W'(pop);
        wr_idx = pop ? (cnt_q - CNT_W'(1)) : cnt_q;
        fifo_d = fifo_q;
        if (pop) begin
            for (int i = 0; i < MAX_OUT - 1; i++) begin
                fifo_d[i] = fifo_q[i+1];
            end
            fifo_d[MAX_OUT-1] = 1'b0;
        end
        if (accept) begin
            for (int i = 0; i < MAX_OUT; i++) begin
                if (CNT_W'(i) == wr_idx) begin
                    fifo_d[i] = sel;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q    <= 1'b0;
            lock_q    <= 1'b0;
            lock_id_q <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            fifo_q    <= '0;
        end else begin
            last_q    <= last_d;
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            fifo_q    <= fifo_d;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: cycle-stepped masters and sp_ram-like slave with a response queue,
// an owner/data scoreboard and per-scenario tasks.
module tb_mem_port_arbiter;
    localparam int MAX_OUT = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_OUT(MAX_OUT)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          lat      = 1;
    logic [31:0] mem [0:255];
    logic [32:0] exp_q[$];
    int          due_q[$];
    logic [31:0] rsp_q[$];
    int          grant_log[$];
    logic        err_exp = 1'b0;
    logic        err_nxt = 1'b0;

    // ---------------- driver tasks ----------------
    task automatic set_m0(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        bus.m0_req_i = req; bus.m0_we_i = we; bus.m0_addr_i = addr;
        bus.m0_be_i = req ? 4'hF : 4'h0; bus.m0_wdata_i = wdata;
    endtask

    task automatic set_m1(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        bus.m1_req_i = req; bus.m1_we_i = we; bus.m1_addr_i = addr;
        bus.m1_be_i = req ? 4'hF : 4'h0; bus.m1_wdata_i = wdata;
    endtask

    task automatic drive_idle();
        set_m0(1'b0, 1'b0, 32'h0, 32'h0);
        set_m1(1'b0, 1'b0, 32'h0, 32'h0);
        bus.mem_gnt_i = 1'b1; bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = 32'h0;
    endtask

    // Drive the slave side, then sample and score everything visible this cycle.
    task automatic cyc_begin();
        int          out_before;
        int          id;
        logic        any_req;
        logic [32:0] e;
        logic [31:0] data;
        logic [68:0] act_pl;
        logic [68:0] exp_pl;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = 32'h0;
        if (due_q.size() > 0 && due_q[0] <= cyc) begin
            bus.mem_rvalid_i = 1'b1;
            bus.mem_rdata_i  = rsp_q[0];
        end
        #2;
        out_before = exp_q.size();
        any_req = bus.m0_req_i | bus.m1_req_i;
        n_checks++;
        if (bus.mem_req_o !== (any_req && out_before < MAX_OUT))
            $display("FAIL mem_req cyc=%0d: got %b want %b", cyc, bus.mem_req_o, (any_req && out_before < MAX_OUT));
        else n_pass++;
        n_checks++;
        if (bus.protocol_err_o !== err_exp)
            $display("FAIL protocol_err cyc=%0d: got %b want %b", cyc, bus.protocol_err_o, err_exp);
        else n_pass++;
        if (bus.mem_rvalid_i) begin
            void'(due_q.pop_front());
            void'(rsp_q.pop_front());
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if ({bus.m1_rvalid_o, bus.m0_rvalid_o} !== (e[32] ? 2'b10 : 2'b01))
                    $display("FAIL rvalid_route cyc=%0d: got %b want owner m%0d", cyc,
                             {bus.m1_rvalid_o, bus.m0_rvalid_o}, e[32]);
                else n_pass++;
                n_checks++;
                if ((e[32] ? bus.m1_rdata_o : bus.m0_rdata_o) !== e[31:0])
                    $display("FAIL rdata cyc=%0d: got %h want %h", cyc,
                             (e[32] ? bus.m1_rdata_o : bus.m0_rdata_o), e[31:0]);
                else n_pass++;
            end else begin
                err_nxt = 1'b1;
                n_checks++;
                if ({bus.m1_rvalid_o, bus.m0_rvalid_o} !== 2'b00)
                    $display("FAIL stray_rvalid cyc=%0d: got %b want 00", cyc, {bus.m1_rvalid_o, bus.m0_rvalid_o});
                else n_pass++;
            end
        end else begin
            n_checks++;
            if ({bus.m1_rvalid_o, bus.m0_rvalid_o} !== 2'b00)
                $display("FAIL idle_rvalid cyc=%0d: got %b want 00", cyc, {bus.m1_rvalid_o, bus.m0_rvalid_o});
            else n_pass++;
        end
        act_pl = {bus.mem_we_o, bus.mem_addr_o, bus.mem_be_o, bus.mem_wdata_o};
        if (bus.mem_req_o && bus.mem_gnt_i) begin
            id = bus.m1_gnt_o ? 1 : 0;
            n_checks++;
            if ((bus.m0_gnt_o ^ bus.m1_gnt_o) !== 1'b1)
                $display("FAIL gnt_onehot cyc=%0d: got %b want one-hot", cyc, {bus.m1_gnt_o, bus.m0_gnt_o});
            else n_pass++;
            exp_pl = id == 1 ? {bus.m1_we_i, bus.m1_addr_i, bus.m1_be_i, bus.m1_wdata_i}
                             : {bus.m0_we_i, bus.m0_addr_i, bus.m0_be_i, bus.m0_wdata_i};
            n_checks++;
            if (act_pl !== exp_pl)
                $display("FAIL payload cyc=%0d: got %h want %h", cyc, act_pl, exp_pl);
            else n_pass++;
            grant_log.push_back(id);
            if (exp_pl[68]) begin
                mem[exp_pl[45:38]] = exp_pl[31:0];
                data = 32'h0;
            end else begin
                data = mem[exp_pl[45:38]];
            end
            exp_q.push_back({id[0], data});
            due_q.push_back(cyc + lat);
            rsp_q.push_back(data);
        end else begin
            n_checks++;
            if ({bus.m1_gnt_o, bus.m0_gnt_o} !== 2'b00)
                $display("FAIL no_gnt cyc=%0d: got %b want 00", cyc, {bus.m1_gnt_o, bus.m0_gnt_o});
            else n_pass++;
            if (!bus.mem_req_o) begin
                n_checks++;
                if (act_pl !== 69'h0)
                    $display("FAIL idle_payload cyc=%0d: got %h want 0", cyc, act_pl);
                else n_pass++;
            end
        end
    endtask

    task automatic cyc_end();
        @(posedge clk);
        #1;
        cyc++;
        if (err_nxt) err_exp = 1'b1;
        err_nxt = 1'b0;
    endtask

    task automatic run_cycle();
        cyc_begin();
        cyc_end();
    endtask

    task automatic drain();
        drive_idle();
        for (int i = 0; i < 20 && (exp_q.size() > 0 || due_q.size() > 0); i++) run_cycle();
        n_checks++;
        if (exp_q.size() != 0)
            $display("FAIL drain_timeout: got %0d outstanding want 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        rst_n = 1'b1;
        exp_q.delete();
        grant_log.delete();
        err_exp = 1'b0;
        err_nxt = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        #1;
        n_checks++;
        if ({bus.mem_req_o, bus.mem_we_o, bus.m0_gnt_o, bus.m1_gnt_o} !== 4'b0000)
            $display("FAIL reset_req_gnt: got %b want 0000", {bus.mem_req_o, bus.mem_we_o, bus.m0_gnt_o, bus.m1_gnt_o});
        else n_pass++;
        n_checks++;
        if ({bus.m0_rvalid_o, bus.m1_rvalid_o, bus.protocol_err_o} !== 3'b000)
            $display("FAIL reset_rvalid_err: got %b want 000", {bus.m0_rvalid_o, bus.m1_rvalid_o, bus.protocol_err_o});
        else n_pass++;
        n_checks++;
        if ({bus.mem_addr_o, bus.mem_be_o, bus.mem_wdata_o} !== 68'h0)
            $display("FAIL reset_payload: got %h want 0", {bus.mem_addr_o, bus.mem_be_o, bus.mem_wdata_o});
        else n_pass++;
        @(posedge clk);
        #1;
        cyc++;
        rst_n = 1'b1;
        run_cycle();
    endtask

    task automatic test_single_master();
        lat = 1;
        mem[8'h40] = 32'h1234_5678;
        set_m0(1'b1, 1'b0, 32'h100, 32'h0);
        cyc_begin();
        n_checks++;
        if ({bus.mem_req_o, bus.m0_gnt_o, bus.m1_gnt_o} !== 3'b110)
            $display("FAIL single_gnt: got %b want 110", {bus.mem_req_o, bus.m0_gnt_o, bus.m1_gnt_o});
        else n_pass++;
        n_checks++;
        if (bus.mem_addr_o !== 32'h100)
            $display("FAIL single_addr: got %h want 00000100", bus.mem_addr_o);
        else n_pass++;
        cyc_end();
        set_m0(1'b0, 1'b0, 32'h0, 32'h0);
        cyc_begin();
        n_checks++;
        if ({bus.m0_rvalid_o, bus.m1_rvalid_o, bus.m1_gnt_o} !== 3'b100)
            $display("FAIL single_rvalid: got %b want 100", {bus.m0_rvalid_o, bus.m1_rvalid_o, bus.m1_gnt_o});
        else n_pass++;
        n_checks++;
        if (bus.m0_rdata_o !== 32'h1234_5678)
            $display("FAIL single_rdata: got %h want 12345678", bus.m0_rdata_o);
        else n_pass++;
        cyc_end();
    endtask

    task automatic test_first_tie();
        int exp_order[4] = '{1, 0, 1, 0};
        drain();
        apply_reset();
        lat = 1;
        set_m0(1'b1, 1'b0, 32'h0, 32'h0);
        set_m1(1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF);
        repeat (4) run_cycle();
        drain();
        n_checks++;
        if (grant_log.size() != 4)
            $display("FAIL tie_count: got %0d want 4", grant_log.size());
        else n_pass++;
        for (int i = 0; i < 4 && i < grant_log.size(); i++) begin
            n_checks++;
            if (grant_log[i] != exp_order[i])
                $display("FAIL tie_order[%0d]: got m%0d want m%0d", i, grant_log[i], exp_order[i]);
            else n_pass++;
        end
        set_m0(1'b1, 1'b0, 32'h200, 32'h0);
        run_cycle();
        set_m0(1'b0, 1'b0, 32'h0, 32'h0);
        cyc_begin();
        n_checks++;
        if ({bus.m0_rvalid_o, bus.m0_rdata_o} !== {1'b1, 32'hDEAD_BEEF})
            $display("FAIL tie_readback: got %b/%h want 1/deadbeef", bus.m0_rvalid_o, bus.m0_rdata_o);
        else n_pass++;
        cyc_end();
    endtask

    task automatic test_lock_hold();
        drain();
        bus.mem_gnt_i = 1'b0;
        set_m0(1'b1, 1'b0, 32'h40, 32'h0);
        for (int c = 0; c < 3; c++) begin
            if (c == 1) set_m1(1'b1, 1'b0, 32'h80, 32'h0);
            cyc_begin();
            n_checks++;
            if ({bus.mem_addr_o, bus.m0_gnt_o, bus.m1_gnt_o} !== {32'h40, 2'b00})
                $display("FAIL lock_addr c%0d: got %h/%b%b want 00000040/00", c,
                         bus.mem_addr_o, bus.m0_gnt_o, bus.m1_gnt_o);
            else n_pass++;
            cyc_end();
        end
        bus.mem_gnt_i = 1'b1;
        cyc_begin();
        n_checks++;
        if ({bus.m0_gnt_o, bus.m1_gnt_o} !== 2'b10)
            $display("FAIL lock_first: got %b want 10", {bus.m0_gnt_o, bus.m1_gnt_o});
        else n_pass++;
        cyc_end();
        set_m0(1'b0, 1'b0, 32'h0, 32'h0);
        cyc_begin();
        n_checks++;
        if ({bus.m0_gnt_o, bus.m1_gnt_o} !== 2'b01)
            $display("FAIL lock_second: got %b want 01", {bus.m0_gnt_o, bus.m1_gnt_o});
        else n_pass++;
        cyc_end();
        drain();
    endtask

    task automatic test_outstanding();
        grant_log.delete();
        lat = 3;
        set_m0(1'b1, 1'b0, 32'h10, 32'h0);
        set_m1(1'b1, 1'b0, 32'h14, 32'h0);
        for (int c = 0; c < 10; c++) begin
            cyc_begin();
            if (c == 2 || c == 3) begin
                n_checks++;
                if (bus.mem_req_o !== 1'b0)
                    $display("FAIL outst_stall c%0d: got %b want 0", c, bus.mem_req_o);
                else n_pass++;
            end
            cyc_end();
        end
        drain();
        lat = 1;
        n_checks++;
        if (grant_log.size() != 6)
            $display("FAIL outst_count: got %0d want 6", grant_log.size());
        else n_pass++;
        for (int i = 0; i < 6 && i < grant_log.size(); i++) begin
            n_checks++;
            if (grant_log[i] != i % 2)
                $display("FAIL outst_order[%0d]: got m%0d want m%0d", i, grant_log[i], i % 2);
            else n_pass++;
        end
    endtask

    task automatic test_push_pop();
        lat = 1;
        set_m0(1'b1, 1'b0, 32'h20, 32'h0);
        run_cycle();
        set_m0(1'b0, 1'b0, 32'h0, 32'h0);
        set_m1(1'b1, 1'b0, 32'h24, 32'h0);
        cyc_begin();
        n_checks++;
        if ({bus.m0_rvalid_o, bus.m1_rvalid_o, bus.m1_gnt_o} !== 3'b101)
            $display("FAIL pushpop_same: got %b want 101", {bus.m0_rvalid_o, bus.m1_rvalid_o, bus.m1_gnt_o});
        else n_pass++;
        cyc_end();
        set_m1(1'b0, 1'b0, 32'h0, 32'h0);
        cyc_begin();
        n_checks++;
        if ({bus.m0_rvalid_o, bus.m1_rvalid_o} !== 2'b01)
            $display("FAIL pushpop_next: got %b want 01", {bus.m0_rvalid_o, bus.m1_rvalid_o});
        else n_pass++;
        cyc_end();
        drain();
    endtask

    task automatic test_reset_mid();
        lat = 3;
        set_m0(1'b1, 1'b0, 32'h30, 32'h0);
        run_cycle();
        set_m0(1'b0, 1'b0, 32'h0, 32'h0);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.m0_rvalid_o, bus.m1_rvalid_o, bus.protocol_err_o, bus.mem_req_o} !== 4'b0000)
            $display("FAIL midreset_outputs: got %b want 0000",
                     {bus.m0_rvalid_o, bus.m1_rvalid_o, bus.protocol_err_o, bus.mem_req_o});
        else n_pass++;
        @(posedge clk);
        #1;
        cyc++;
        rst_n = 1'b1;
        exp_q.delete();
        lat = 1;
        repeat (4) run_cycle();
        n_checks++;
        if (bus.protocol_err_o !== 1'b1)
            $display("FAIL midreset_err_set: got %b want 1", bus.protocol_err_o);
        else n_pass++;
        set_m1(1'b1, 1'b0, 32'h34, 32'h0);
        run_cycle();
        drain();
        n_checks++;
        if (bus.protocol_err_o !== 1'b1)
            $display("FAIL midreset_err_sticky: got %b want 1", bus.protocol_err_o);
        else n_pass++;
        apply_reset();
        n_checks++;
        if (bus.protocol_err_o !== 1'b0)
            $display("FAIL midreset_err_clear: got %b want 0", bus.protocol_err_o);
        else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = (i * 32'h0101_0101) ^ 32'hA5A5_0000;
        test_reset();
        test_single_master();
        test_first_tie();
        test_lock_hold();
        test_outstanding();
        test_push_pop();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-master to one-slave arbiter that shares a single `sp_ram` port between the `zeroriscy_core` instruction and data interfaces in a unified-memory SoC variant. It speaks the core's req/gnt/rvalid protocol on every side. It arbitrates round-robin and holds a stalled selection until it is granted. It routes each response back to its issuer through an in-order owner FIFO.

## Interface
Parameters:
- `ADDR_W`, 32, address width on all ports.
- `DATA_W`, 32, data width; byte-enable width is `DATA_W/8`.
- `MAX_OUT`, 2, maximum accepted-but-unanswered transactions; legal range 1..4.

Ports:
- `clk_i`  in  1  clock; single clock domain.
- `rst_ni`  in  1  reset, asynchronous assert, active-low.
- `m0_req_i`, `m0_we_i`  in  1  master 0 (instruction) request, write enable.
- `m0_addr_i` in ADDR_W; `m0_be_i` in DATA_W/8; `m0_wdata_i` in DATA_W  master 0 request payload.
- `m0_gnt_o`, `m0_rvalid_o`  out  1  master 0 grant, response valid.
- `m0_rdata_o`  out  DATA_W  master 0 read data.
- `m1_*`  same set as `m0_*`  master 1 (data).
- `mem_req_o`, `mem_we_o`  out  1  slave request, write enable.
- `mem_addr_o` out ADDR_W; `mem_be_o` out DATA_W/8; `mem_wdata_o` out DATA_W  slave request payload.
- `mem_gnt_i`, `mem_rvalid_i`  in  1  slave grant, response valid.
- `mem_rdata_i`  in  DATA_W  slave read data.
- `protocol_err_o`  out  1  sticky; set when `mem_rvalid_i` arrives with no outstanding transaction.

## Operation
- State:
  - `last_q`: id of the last granted master.
  - `lock_q`/`lock_id_q`: a presented request is awaiting grant.
  - Owner FIFO of 1-bit ids, depth MAX_OUT.
  - `cnt_q`: number of outstanding transactions, 0..MAX_OUT.
- Selection (combinational):
  - If `lock_q` is set, `sel = lock_id_q`.
  - Otherwise, if exactly one master requests, it is selected.
  - Otherwise, if both request, `sel = ~last_q`.
- `mem_req_o = req[sel] & (cnt_q < MAX_OUT)`. Address, we, be and wdata are muxed from `sel`. The payload is don't-care when `mem_req_o=0`, but the bench checks that it is 0.
- `mX_gnt_o = mem_req_o & mem_gnt_i & (sel==X)`. The non-selected master never sees a grant.
- Accept = `mem_req_o & mem_gnt_i`. On accept:
  - Push `sel` into the FIFO.
  - Set `last_q <= sel`.
  - Clear `lock_q`.
- Present without grant (`mem_req_o & ~mem_gnt_i`): set `lock_q`, `lock_id_q <= sel`.
- If the locked master deasserts req (a protocol violation by the master), clear the lock on the next edge.
- Response handling on `mem_rvalid_i`:
  - FIFO non-empty: pop the head, assert `m<head>_rvalid_o` in the same cycle.
  - FIFO empty: drop the response and set `protocol_err_o`.
- `mem_rdata_i` is broadcast to both `mX_rdata_o` every cycle.
- Simultaneous accept and rvalid: push and pop in the same cycle, `cnt_q` unchanged. The response belongs to the head entry, never to the entry being pushed.
- FIFO full (`cnt_q==MAX_OUT`):
  - `mem_req_o` is held at 0 and no grants are issued.
  - Lock state is retained.
  - The limit is not bypassed even if an rvalid pops in the same cycle (the full check uses registered `cnt_q`).
- Reset:
  - `last_q=0`, so master 1 wins the first tie.
  - `lock_q=0`, FIFO empty, `cnt_q=0`, `protocol_err_o=0`.
  - Responses in flight at reset are lost. Any that arrive later set `protocol_err_o`.
  - `protocol_err_o` clears only on reset.

## Timing
- Zero-cycle combinational paths:
  - `mX_req_i` to `mem_req_o` and payload.
  - `mem_gnt_i` to `mX_gnt_o`.
  - `mem_rvalid_i` to `mX_rvalid_o`.
- No added latency. With `sp_ram` (grant in the request cycle, rvalid one cycle later), each master sees the same timing as a direct connection.
- Throughput is one accept per cycle. When both masters request continuously, grants alternate every cycle.
- All register updates occur on the `clk_i` rising edge. Reset is asynchronous.
- Reset values of outputs:
  - All `*_gnt_o`, `*_rvalid_o`, `mem_req_o`, `mem_we_o` and `protocol_err_o` are 0.
  - Payload outputs are 0 while no master requests.

## Test plan
- **Single master:** m0 reads 0x100 with gnt tied 1 → `mem_req_o`=1 and `m0_gnt_o`=1 in cycle 0. `m0_rvalid_o`=1 in cycle 1 with `m0_rdata_o`=mem[0x100]. `m1_gnt_o` and `m1_rvalid_o` stay 0.
- **First tie after reset:** both masters request continuously (m0 addr 0x0, m1 write 0x200=0xDEADBEEF) → grant order m1, m0, m1, m0. Each rvalid goes to the issuer in order. A later read of 0x200 returns 0xDEADBEEF.
- **Lock hold:** m0 requests with `mem_gnt_i`=0 for 3 cycles, m1 requests from cycle 1 → `mem_addr_o` stays on m0's address for all 3 cycles. m0 is granted first when gnt rises, m1 on the following cycle.
- **Outstanding limit:** MAX_OUT=2, rvalid delayed 3 cycles → after two accepts `mem_req_o`=0 until the first rvalid. Exactly 2 transactions are outstanding at any time. Responses are routed in FIFO order.
- **Simultaneous push/pop:** accept on m1 in the same cycle as the rvalid for an earlier m0 access → `m0_rvalid_o`=1, `m1_rvalid_o`=0, `cnt_q` unchanged.
- **Reset mid-operation:** assert `rst_ni`=0 with one access outstanding, release, then drive a stray `mem_rvalid_i` → no `mX_rvalid_o` asserted, `protocol_err_o`=1 and held until the next reset.
